// File: rtl/lc3b_mc_alu.sv
// lc3b_mc_alu: LC-3b ALU with single-cycle logic/shift ops plus
// iterative unsigned shift-add multiply and restoring divide.
module lc3b_mc_alu #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             illegal_op
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             dz_pend_q;
  logic             il_pend_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH:0]   acc_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic             il_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] rhi_q;

  logic [SHAMT_W-1:0] shamt;
  logic               big;
  logic [WIDTH-1:0]   alu_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   q_d;

  assign shamt = b[SHAMT_W-1:0];
  assign big   = {1'b0, shamt} >= (SHAMT_W+1)'(WIDTH);

  always_comb begin
    alu_d = '0;
    case (op)
      4'd0: alu_d = a + b;
      4'd1: alu_d = a & b;
      4'd2: alu_d = ~a;
      4'd3: alu_d = a;
      4'd4: alu_d = big ? '0 : a << shamt;
      4'd5: alu_d = big ? '0 : a >> shamt;
      4'd6: alu_d = big ? {WIDTH{a[WIDTH-1]}}
                        : WIDTH'($signed(a) >>> shamt);
      default: alu_d = '0;
    endcase
  end

  // acc holds the product high half / partial remainder, q the low half / quotient
  always_comb begin
    sum   = acc_q + (q_q[0] ? {1'b0, m_q} : '0);
    shl   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial = shl - {1'b0, m_q};
    ge    = shl >= {1'b0, m_q};
    if (is_div_q) begin
      acc_d = ge ? trial : shl;
      q_d   = {q_q[WIDTH-2:0], ge};
    end else begin
      acc_d = {1'b0, sum[WIDTH:1]};
      q_d   = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      il_pend_q <= 1'b0;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      il_q      <= 1'b0;
      res_q     <= '0;
      rhi_q     <= '0;
    end else begin
      busy_q <= state_q != S_IDLE;
      done_q <= state_q == S_DONE;
      unique case (state_q)
        S_IDLE: begin
          // busy_q still high here means this is the done cycle
          if (start && !busy_q) begin
            is_div_q  <= op == 4'd8;
            dz_pend_q <= 1'b0;
            il_pend_q <= 1'b0;
            dz_q      <= 1'b0;
            il_q      <= 1'b0;
            acc_q     <= '0;
            state_q   <= S_DONE;
            if (op == 4'd7) begin
              m_q     <= a;
              q_q     <= b;
              cnt_q   <= CW'(WIDTH);
              state_q <= S_RUN;
            end else if (op == 4'd8 && b != '0) begin
              m_q     <= b;
              q_q     <= a;
              cnt_q   <= CW'(WIDTH);
              state_q <= S_RUN;
            end else if (op == 4'd8) begin
              q_q       <= '1;
              acc_q     <= {1'b0, a};
              dz_pend_q <= 1'b1;
            end else if (op > 4'd8) begin
              q_q       <= '0;
              il_pend_q <= 1'b1;
            end else begin
              q_q <= alu_d;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_DONE;
        end
        S_DONE: begin
          res_q   <= q_q;
          rhi_q   <= acc_q[WIDTH-1:0];
          dz_q    <= dz_pend_q;
          il_q    <= il_pend_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign result_hi   = rhi_q;
  assign div_by_zero = dz_q;
  assign illegal_op  = il_q;

endmodule

// File: tb/tb_lc3b_mc_alu.sv
// tb_lc3b_mc_alu: random and directed checks of lc3b_mc_alu at
// WIDTH=16 and WIDTH=8 against an arithmetic reference model.
module tb_lc3b_mc_alu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st, use8;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        start16, start8;
  logic        busy16, done16, dz16, il16;
  logic [15:0] r16, h16;
  logic        busy8, done8, dz8, il8;
  logic [7:0]  r8, h8;

  assign start16 = st & ~use8;
  assign start8  = st & use8;

  lc3b_mc_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op),
    .a(a), .b(b), .busy(busy16), .done(done16),
    .result(r16), .result_hi(h16),
    .div_by_zero(dz16), .illegal_op(il16)
  );

  lc3b_mc_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .busy(busy8), .done(done8),
    .result(r8), .result_hi(h8),
    .div_by_zero(dz8), .illegal_op(il8)
  );

  logic        c_busy, c_done, c_dz, c_il;
  logic [15:0] c_res, c_hi;

  always_comb begin
    if (use8) begin
      c_busy = busy8; c_done = done8; c_dz = dz8; c_il = il8;
      c_res = {8'h00, r8}; c_hi = {8'h00, h8};
    end else begin
      c_busy = busy16; c_done = done16; c_dz = dz16; c_il = il16;
      c_res = r16; c_hi = h16;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input int w, input logic [3:0] o,
                       input logic [15:0] xi, input logic [15:0] yi,
                       output logic [15:0] lo, output logic [15:0] hi,
                       output logic dz, output logic il, output int lat);
    logic [31:0] m, x, y, r, h;
    int s;
    m = (32'd1 << w) - 32'd1;
    x = {16'd0, xi} & m;
    y = {16'd0, yi} & m;
    s = int'(y) % w;
    r = 0; h = 0; dz = 0; il = 0; lat = 1;
    case (o)
      4'd0: r = (x + y) & m;
      4'd1: r = x & y;
      4'd2: r = ~x & m;
      4'd3: r = x;
      4'd4: r = (x << s) & m;
      4'd5: r = x >> s;
      4'd6: r = x[w-1] ? ((x >> s) | (m & ~(m >> s))) : (x >> s);
      4'd7: begin
        r = (x * y) & m; h = (x * y) >> w; lat = w + 1;
      end
      4'd8: begin
        if (y == 0) begin
          r = m; h = x; dz = 1;
        end else begin
          r = x / y; h = x % y; lat = w + 1;
        end
      end
      default: il = 1;
    endcase
    lo = r[15:0];
    hi = h[15:0];
  endtask

  // poke>0: stray add start before that edge; poke<0: start in done cycle
  task automatic issue(input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y, input int poke);
    int w, lat, n;
    logic [15:0] elo, ehi;
    logic edz, eil;
    w = use8 ? 8 : 16;
    model(w, o, x, y, elo, ehi, edz, eil, lat);
    @(negedge clk);
    st = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    st = 1'b0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    n = 0;
    while (n < 40) begin
      if (n + 1 == poke) begin
        st = 1'b1; op = 4'd0;
      end
      @(posedge clk); #1;
      st = 1'b0;
      n++;
      if (c_done) break;
      check("busy_run", c_busy, 1);
    end
    check("latency", n, lat);
    check("busy_done", c_busy, 1);
    check("result", c_res, elo);
    check("result_hi", c_hi, ehi);
    check("div_by_zero", c_dz, edz);
    check("illegal_op", c_il, eil);
    if (poke < 0) begin
      st = 1'b1; op = 4'd0;
    end
    @(posedge clk); #1;
    st = 1'b0;
    check("done_pulse", c_done, 0);
    check("busy_idle", c_busy, 0);
    @(posedge clk); #1;
    check("no_restart", c_busy, 0);
    check("hold_result", c_res, elo);
    check("hold_hi", c_hi, ehi);
    check("hold_flags", {c_dz, c_il}, {edz, eil});
  endtask

  initial begin
    int n;
    logic [3:0] ro;
    logic [15:0] ra, rb;
    rst = 1'b1; st = 1'b0; use8 = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {busy16, busy8}, 0);
    check("rst_done", {done16, done8}, 0);
    check("rst_result", {r16, r8}, 0);
    check("rst_result_hi", {h16, h8}, 0);
    check("rst_flags", {dz16, il16, dz8, il8}, 0);
    rst = 1'b0;

    issue(4'd0, 16'hFFFF, 16'h0001, 0);
    issue(4'd6, 16'h8000, 16'h0003, 0);
    issue(4'd5, 16'h8000, 16'h0003, 0);
    issue(4'd4, 16'h0001, 16'h000F, 0);
    issue(4'd7, 16'h1234, 16'h0100, 5);
    issue(4'd8, 16'd100, 16'd7, 0);
    issue(4'd8, 16'h00AB, 16'h0000, 0);
    issue(4'd12, 16'h5555, 16'h3333, -1);
    issue(4'd1, 16'hF0F0, 16'h3C3C, 0);

    // abort a multiply in flight
    @(negedge clk);
    st = 1'b1; op = 4'd7; a = 16'h1234; b = 16'h0100;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy16, 0);
    check("abort_done", done16, 0);
    check("abort_out", {r16, h16, dz16, il16}, 0);
    rst = 1'b0;
    n = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done16 || busy16) n++;
    end
    check("abort_no_done", n, 0);
    issue(4'd0, 16'h1111, 16'h2222, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      issue(ro, ra, rb, 0);
    end

    use8 = 1'b1;
    issue(4'd7, 16'h00FF, 16'h00FF, 0);
    issue(4'd8, 16'h00C8, 16'h0009, 0);
    issue(4'd6, 16'h0090, 16'h0002, 0);
    for (int i = 0; i < 20; i++) begin
      ro = 4'($urandom_range(0, 10));
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ro, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
